// File: rtl/somador_acumulador_pkg.sv
// Shared constants, FSM state encoding and BCD digit type for the adder/accumulator.
package pacote_somador;

    localparam int LARGURA   = 8;
    localparam int N_DIGITOS = 3;

    typedef logic [3:0] digito_t;

    localparam digito_t ADD3_LIMIAR = 4'd5;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        DESLOCA = 2'd2,
        CONCLUI = 2'd3
    } estado_t;

endpackage

// File: rtl/somador_acumulador_bin_bcd_serial.sv
// Serial shift-add-3 converter: unsigned magnitude plus sign to N_DIGITOS BCD digits.
// A start pulse abandons any conversion in flight and reloads from the current inputs.
module bin_bcd_serial #(
    parameter int LARGURA   = 8,
    parameter int N_DIGITOS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LARGURA-1:0]       mag,
    input  logic                     sinal,
    output logic [4*N_DIGITOS-1:0]   digitos,
    output logic                     negativo,
    output logic                     valido,
    output logic                     ocupado
);
    import pacote_somador::*;

    localparam int CW = $clog2(LARGURA + 1);

    estado_t                  estado_reg, estado_next;
    logic [LARGURA-1:0]       mag_reg, mag_next;
    logic [4*N_DIGITOS-1:0]   bcd_reg, bcd_next, bcd_aj;
    logic [CW-1:0]            cnt_reg, cnt_next;
    logic                     sinal_reg, sinal_next;
    logic [4*N_DIGITOS-1:0]   digitos_reg, digitos_next;
    logic                     negativo_reg, negativo_next;
    logic                     valido_reg, valido_next;

    // Every nibble of 5 or more gets +3 so the following left shift carries into the next digit.
    for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_add3
        assign bcd_aj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= ADD3_LIMIAR)
                                   ? bcd_reg[4*gi +: 4] + 4'd3
                                   : bcd_reg[4*gi +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg   <= OCIOSO;
            mag_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            sinal_reg    <= 1'b0;
            digitos_reg  <= '0;
            negativo_reg <= 1'b0;
            valido_reg   <= 1'b1;
        end else begin
            estado_reg   <= estado_next;
            mag_reg      <= mag_next;
            bcd_reg      <= bcd_next;
            cnt_reg      <= cnt_next;
            sinal_reg    <= sinal_next;
            digitos_reg  <= digitos_next;
            negativo_reg <= negativo_next;
            valido_reg   <= valido_next;
        end
    end

    always_comb begin
        estado_next   = estado_reg;
        mag_next      = mag_reg;
        bcd_next      = bcd_reg;
        cnt_next      = cnt_reg;
        sinal_next    = sinal_reg;
        digitos_next  = digitos_reg;
        negativo_next = negativo_reg;
        valido_next   = valido_reg;

        // A new total always wins: hold everything and (re)enter CARREGA next cycle.
        if (start) begin
            estado_next = CARREGA;
        end else begin
            case (estado_reg)
                OCIOSO: ;
                CARREGA: begin
                    mag_next    = mag;
                    sinal_next  = sinal;
                    bcd_next    = '0;
                    cnt_next    = CW'(LARGURA);
                    valido_next = 1'b0;
                    estado_next = DESLOCA;
                end
                DESLOCA: begin
                    {bcd_next, mag_next} = {bcd_aj, mag_reg} << 1;
                    cnt_next             = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1))
                        estado_next = CONCLUI;
                end
                CONCLUI: begin
                    digitos_next  = bcd_reg;
                    negativo_next = sinal_reg;
                    valido_next   = 1'b1;
                    estado_next   = OCIOSO;
                end
                default: estado_next = OCIOSO;
            endcase
        end
    end

    assign digitos  = digitos_reg;
    assign negativo = negativo_reg;
    assign valido   = valido_reg;
    assign ocupado  = (estado_reg != OCIOSO);

endmodule

// File: rtl/somador_acumulador.sv
// Signed 8-bit accumulator driven by a debounced add button, with serial BCD readout.
// Define SATURACAO_EN to saturate the add at 0x7F/0x80 instead of wrapping.
module somador_acumulador #(
    parameter int LARGURA   = 8,
    parameter int N_DIGITOS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LARGURA-1:0] valor,
    input  logic               somar,
    input  logic               limpar,
    output logic [LARGURA-1:0] acc,
    output logic               negativo,
    output logic [3:0]         centena,
    output logic [3:0]         dezena,
    output logic [3:0]         unidade,
    output logic               bcd_valido,
    output logic               ocupado
);
    import pacote_somador::*;

    logic                     somar_s1_reg, somar_s2_reg, somar_ant_reg;
    logic                     pulso_soma;
    logic                     atualiza;
    logic [LARGURA-1:0]       acc_reg, acc_next;
    logic [LARGURA-1:0]       soma_bruta, soma_final;
    logic [LARGURA-1:0]       mag;
    logic [4*N_DIGITOS-1:0]   digitos;

    // somar is asynchronous: two flops against metastability, a third for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            somar_s1_reg  <= 1'b0;
            somar_s2_reg  <= 1'b0;
            somar_ant_reg <= 1'b0;
            acc_reg       <= '0;
        end else begin
            somar_s1_reg  <= somar;
            somar_s2_reg  <= somar_s1_reg;
            somar_ant_reg <= somar_s2_reg;
            acc_reg       <= acc_next;
        end
    end

    assign pulso_soma = somar_s2_reg & ~somar_ant_reg;
    assign soma_bruta = acc_reg + valor;

`ifdef SATURACAO_EN
    logic estouro;
    assign estouro    = (acc_reg[LARGURA-1] == valor[LARGURA-1]) &&
                        (soma_bruta[LARGURA-1] != acc_reg[LARGURA-1]);
    assign soma_final = !estouro ? soma_bruta
                      : acc_reg[LARGURA-1] ? {1'b1, {(LARGURA-1){1'b0}}}
                      : {1'b0, {(LARGURA-1){1'b1}}};
`else
    assign soma_final = soma_bruta;
`endif

    always_comb begin
        acc_next = acc_reg;
        if (limpar)
            acc_next = '0;
        else if (pulso_soma)
            acc_next = soma_final;
    end

    assign atualiza = limpar | pulso_soma;

    // Magnitude as unsigned: the most negative value maps to 2^(LARGURA-1).
    assign mag = acc_reg[LARGURA-1] ? (~acc_reg) + {{(LARGURA-1){1'b0}}, 1'b1} : acc_reg;

    bin_bcd_serial #(
        .LARGURA   (LARGURA),
        .N_DIGITOS (N_DIGITOS)
    ) u_bin_bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (atualiza),
        .mag      (mag),
        .sinal    (acc_reg[LARGURA-1]),
        .digitos  (digitos),
        .negativo (negativo),
        .valido   (bcd_valido),
        .ocupado  (ocupado)
    );

    assign acc     = acc_reg;
    assign centena = digitos[11:8];
    assign dezena  = digitos[7:4];
    assign unidade = digitos[3:0];

endmodule

// File: tb/tb_somador_acumulador.sv
// Bench for somador_acumulador: directed scenarios with literal expectations plus
// randomized button/clear activity compared every cycle against an arithmetic model.
module tb_somador_acumulador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] valor = 8'h00;
    logic       somar = 1'b0;
    logic       limpar = 1'b0;
    logic [7:0] acc;
    logic       negativo;
    logic [3:0] centena, dezena, unidade;
    logic       bcd_valido, ocupado;

    int total = 0;
    int bad = 0;

    somador_acumulador dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valor      (valor),
        .somar      (somar),
        .limpar     (limpar),
        .acc        (acc),
        .negativo   (negativo),
        .centena    (centena),
        .dezena     (dezena),
        .unidade    (unidade),
        .bcd_valido (bcd_valido),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    task automatic check(input string nome, input int atual, input int esperado);
        total++;
        if (atual !== esperado) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: press seen by the design two edges after the button rises.
    logic [7:0] m_acc = 8'h00;
    logic       m_valid = 1'b1, m_neg = 1'b0;
    int         m_c = 0, m_d = 0, m_u = 0;
    int         cyc = 0, t_upd = -100;
    logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic [7:0] alvo = 8'h00;

    function automatic logic [7:0] soma_ref(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = $signed(a) + $signed(b);
`ifdef SATURACAO_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 8'h00; m_valid = 1'b1; m_neg = 1'b0;
            m_c = 0; m_d = 0; m_u = 0;
            h1 = 0; h2 = 0; h3 = 0;
            t_upd = -100;
        end else begin
            int mag;
            cyc++;
            if (limpar) begin
                m_acc = 8'h00; t_upd = cyc; alvo = m_acc;
            end else if (h2 && !h3) begin
                m_acc = soma_ref(m_acc, valor); t_upd = cyc; alvo = m_acc;
            end
            h3 = h2; h2 = h1; h1 = somar;
            if (cyc == t_upd + 1) m_valid = 1'b0;
            if (cyc == t_upd + 10) begin
                mag = $signed(alvo);
                m_neg = (mag < 0);
                if (mag < 0) mag = -mag;
                m_c = mag / 100; m_d = (mag / 10) % 10; m_u = mag % 10;
                m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("acc", acc, m_acc);
            check("bcd_valido", bcd_valido, m_valid);
            check("negativo", negativo, m_neg);
            check("centena", centena, m_c);
            check("dezena", dezena, m_d);
            check("unidade", unidade, m_u);
            if (cyc >= t_upd + 1 && cyc <= t_upd + 9)
                check("ocupado_conv", ocupado, 1);
            else if (cyc != t_upd)
                check("ocupado_idle", ocupado, 0);
        end
    end

    task automatic espera(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic aperta(input logic [7:0] v, input int segura);
        @(negedge clk);
        valor = v; somar = 1'b1;
        espera(segura);
        somar = 1'b0;
        espera(14);
    endtask

    task automatic zera;
        @(negedge clk); limpar = 1'b1;
        @(negedge clk); limpar = 1'b0;
        espera(12);
    endtask

    task automatic digitos(input string nome, input int c, input int d, input int u, input int n);
        $display("check %s: acc=%02h digits %0d%0d%0d neg=%0d", nome, acc, centena, dezena, unidade, negativo);
        check({nome, "_c"}, centena, c);
        check({nome, "_d"}, dezena, d);
        check({nome, "_u"}, unidade, u);
        check({nome, "_neg"}, negativo, n);
        check({nome, "_valid"}, bcd_valido, 1);
    endtask

    initial begin
        espera(3);
        check("rst_acc", acc, 0);
        check("rst_valid", bcd_valido, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_dig", {centena, dezena, unidade}, 0);
        #2 rst_n = 1'b1;

        aperta(8'h03, 3);
        check("p1_acc", acc, 8'h03);
        digitos("p1", 0, 0, 3, 0);

        aperta(8'hFD, 3);
        aperta(8'hFD, 3);
        check("p2_acc", acc, 8'hFD);
        digitos("p2", 0, 0, 3, 1);

        aperta(8'h01, 50);
        check("hold_acc", acc, 8'hFE);

        zera();
        aperta(8'h7E, 2);
        aperta(8'h03, 2);
`ifdef SATURACAO_EN
        check("ovf_acc", acc, 8'h7F);
        digitos("ovf", 1, 2, 7, 0);
`else
        check("ovf_acc", acc, 8'h81);
        digitos("ovf", 1, 2, 7, 1);
`endif

        zera();
        aperta(8'h80, 2);
        check("min_acc", acc, 8'h80);
        digitos("min", 1, 2, 8, 1);

        // Clear lands on the same edge as the add pulse: the step must be dropped.
        @(negedge clk); valor = 8'h05; somar = 1'b1;
        espera(2); limpar = 1'b1;
        @(negedge clk); limpar = 1'b0; somar = 1'b0;
        check("clr_pri_acc", acc, 8'h00);
        espera(12);
        digitos("clr_pri", 0, 0, 0, 0);

        // Second press mid-conversion restarts it; only the second total is shown.
        @(negedge clk); valor = 8'd10; somar = 1'b1;
        espera(3); somar = 1'b0;
        @(negedge clk); valor = 8'd20; somar = 1'b1;
        espera(12);
        check("restart_busy_valid", bcd_valido, 0);
        @(negedge clk);
        somar = 1'b0;
        check("restart_acc", acc, 30);
        digitos("restart", 0, 3, 0, 0);

        // Asynchronous reset in the middle of the shift phase.
        @(negedge clk); valor = 8'h7F; somar = 1'b1;
        espera(6); somar = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc", acc, 0);
        check("arst_dig", {centena, dezena, unidade}, 0);
        check("arst_valid", bcd_valido, 1);
        check("arst_ocupado", ocupado, 0);
        check("arst_neg", negativo, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) somar = ~somar;
            limpar = ($urandom_range(0, 24) == 0);
            valor = 8'($urandom);
        end
        @(negedge clk); somar = 1'b0; limpar = 1'b0;
        espera(15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
